// File: rtl/mem_arbiter_if.sv
// Bus bundle between the 6502 core, the DMA/test-loader requester and the shared memory port.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rdy;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_lock;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdy, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, owner,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdy, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, owner,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the shared memory port: CPU priority, bounded DMA starvation,
// lockable DMA bursts and a one-cycle read-return path steered back to the issuing side.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input logic         ph1,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [0:0] CPU_PRI  = 1'b0;
    localparam logic [0:0] DMA_LOCK = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             rd_pend_reg, rd_pend_next;
    logic             rd_owner_reg, rd_owner_next;
    logic             post_rst_reg;

    logic              blocked;
    logic              at_limit;
    logic              dma_win;
    logic              issue_en, issue_we, issue_owner, issue_gnt;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;
    logic              cpu_rvalid_c, dma_rvalid_c;

    // Reset and the cycle following it are quiet: no issue, no read return, CPU not stalled.
    assign blocked  = reset | post_rst_reg;
    assign at_limit = (wait_cnt_reg == CNT_W'(MAX_WAIT));

    always_comb begin
        dma_win = 1'b0;
        if (!blocked) begin
            if (state_reg == DMA_LOCK)
                dma_win = 1'b1;
            else
                dma_win = bus.dma_req & (~bus.cpu_req | at_limit);
        end
    end

    always_comb begin
        issue_en    = 1'b0;
        issue_we    = 1'b0;
        issue_owner = 1'b0;
        issue_gnt   = 1'b0;
        issue_addr  = {ADDR_W{1'b0}};
        issue_wdata = {DATA_W{1'b0}};
        if (!blocked) begin
            if (dma_win & bus.dma_req) begin
                issue_en    = 1'b1;
                issue_we    = bus.dma_we;
                issue_owner = 1'b1;
                issue_gnt   = 1'b1;
                issue_addr  = bus.dma_addr;
                issue_wdata = bus.dma_wdata;
            end else if (~dma_win & bus.cpu_req) begin
                issue_en    = 1'b1;
                issue_we    = bus.cpu_we;
                issue_addr  = bus.cpu_addr;
                issue_wdata = bus.cpu_wdata;
            end
        end
    end

    assign bus.mem_en    = issue_en;
    assign bus.mem_we    = issue_we;
    assign bus.mem_addr  = issue_addr;
    assign bus.mem_wdata = issue_wdata;
    assign bus.owner     = issue_owner;
    assign bus.dma_gnt   = issue_gnt;
    assign bus.cpu_rdy   = ~dma_win;

    // Read data comes straight from memory and is handed only to the side that issued it.
    assign cpu_rvalid_c   = ~blocked & rd_pend_reg & ~rd_owner_reg;
    assign dma_rvalid_c   = ~blocked & rd_pend_reg &  rd_owner_reg;
    assign bus.cpu_rvalid = cpu_rvalid_c;
    assign bus.dma_rvalid = dma_rvalid_c;
    assign bus.cpu_rdata  = cpu_rvalid_c ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.dma_rdata  = dma_rvalid_c ? bus.mem_rdata : {DATA_W{1'b0}};

    always_comb begin
        rd_pend_next  = issue_en & ~issue_we;
        rd_owner_next = issue_owner;

        wait_cnt_next = wait_cnt_reg;
        if (~bus.dma_req | issue_gnt)
            wait_cnt_next = {CNT_W{1'b0}};
        else if (!at_limit)
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);

        state_next = state_reg;
        case (state_reg)
            CPU_PRI:  if (issue_gnt & bus.dma_lock) state_next = DMA_LOCK;
            DMA_LOCK: if (~bus.dma_lock)            state_next = CPU_PRI;
            default:  state_next = CPU_PRI;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_reg    <= CPU_PRI;
            wait_cnt_reg <= {CNT_W{1'b0}};
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= 1'b0;
            post_rst_reg <= 1'b1;
        end else if (post_rst_reg) begin
            state_reg    <= CPU_PRI;
            wait_cnt_reg <= {CNT_W{1'b0}};
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= 1'b0;
            post_rst_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rd_pend_reg  <= rd_pend_next;
            rd_owner_reg <= rd_owner_next;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    logic ph1;
    logic reset;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(3)
    ) dut (
        .ph1(ph1),
        .reset(reset),
        .bus(bus)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Memory block model: writes land at the edge, reads return one cycle later.
    logic [7:0] ram [0:65535];
    always @(posedge ph1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Behavioural model state
    bit       m_locked, m_post, m_rd_pend, m_rd_owner;
    int       m_waited;
    bit [7:0] m_rd_data;

    // Expected outputs for the current cycle
    bit        e_cpu_rdy, e_cpu_rvalid, e_dma_gnt, e_dma_rvalid, e_en, e_we, e_owner;
    bit [7:0]  e_cpu_rdata, e_dma_rdata, e_wdata, e_rd_next;
    bit [15:0] e_addr;
    logic [46:0] exp_vec, obs_vec;

    task automatic drive(input bit cr, input bit cw, input bit [15:0] ca, input bit [7:0] cd,
                         input bit dr, input bit dw, input bit [15:0] da, input bit [7:0] dd,
                         input bit dl, input bit rs);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
        bus.dma_lock = dl; reset = rs;
    endtask

    // Wait for the mid-cycle point and compute what the arbiter must present now.
    task automatic settle();
        bit blk, win;
        @(negedge ph1);
        blk = reset || m_post;
        e_cpu_rdy = 1; e_cpu_rvalid = 0; e_dma_gnt = 0; e_dma_rvalid = 0;
        e_en = 0; e_we = 0; e_owner = 0; e_cpu_rdata = 0; e_dma_rdata = 0;
        e_wdata = 0; e_addr = 0;
        if (!blk) begin
            win = m_locked || (bus.dma_req && (!bus.cpu_req || m_waited == MAX_WAIT));
            e_cpu_rdy = !win;
            if (win && bus.dma_req) begin
                e_en = 1; e_dma_gnt = 1; e_owner = 1;
                e_we = bus.dma_we; e_addr = bus.dma_addr; e_wdata = bus.dma_wdata;
            end else if (!win && bus.cpu_req) begin
                e_en = 1;
                e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
            end
            if (m_rd_pend) begin
                if (m_rd_owner) begin e_dma_rvalid = 1; e_dma_rdata = m_rd_data; end
                else            begin e_cpu_rvalid = 1; e_cpu_rdata = m_rd_data; end
            end
        end
        e_rd_next = ram[e_addr];
        exp_vec = {e_cpu_rdy, e_cpu_rvalid, e_cpu_rdata, e_dma_gnt, e_dma_rvalid, e_dma_rdata,
                   e_en, e_we, e_addr, e_wdata, e_owner};
        obs_vec = {bus.cpu_rdy, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_gnt, bus.dma_rvalid,
                   bus.dma_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.owner};
    endtask

    // Advance one clock and update the model with what this cycle did.
    task automatic tick();
        @(posedge ph1);
        $display("cyc %0d rst=%0d owner=%0d en=%0d we=%0d addr=%h wdata=%h", cyc, reset,
                 e_owner, e_en, e_we, e_addr, e_wdata);
        if (reset) begin
            m_locked = 0; m_waited = 0; m_rd_pend = 0; m_rd_owner = 0; m_post = 1;
        end else if (m_post) begin
            m_locked = 0; m_waited = 0; m_rd_pend = 0; m_rd_owner = 0; m_post = 0;
        end else begin
            m_rd_pend  = e_en && !e_we;
            m_rd_owner = e_owner;
            m_rd_data  = e_rd_next;
            if (!bus.dma_req || e_dma_gnt) m_waited = 0;
            else if (m_waited < MAX_WAIT)  m_waited++;
            if (m_locked)                         m_locked = bus.dma_lock;
            else if (e_dma_gnt && bus.dma_lock)   m_locked = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 16'h1234, 8'h00, 1, 0, 16'h4321, 8'h00, 1, i < 2);
            settle();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL reset_vec cyc %0d got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (i < 3) begin
                checks++;
                if (bus.cpu_rdy !== 1'b1 || bus.mem_en !== 1'b0 || bus.dma_gnt !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_quiet cyc %0d got rdy=%b en=%b gnt=%b want rdy=1 en=0 gnt=0",
                             cyc, bus.cpu_rdy, bus.mem_en, bus.dma_gnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0);
            settle();
            checks++;
            if (bus.mem_en !== 1'b0 || bus.cpu_rdy !== 1'b1 || bus.dma_gnt !== 1'b0
                || obs_vec !== exp_vec) begin
                fails++; $display("FAIL idle cyc %0d got %h want %h", cyc, obs_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_cpu_read();
        ram[16'h0030] = 8'h9D;
        drive(1, 0, 16'h0030, 8'h00, 0, 0, 16'h0, 8'h0, 0, 0);
        settle();
        checks++;
        if (bus.mem_addr !== 16'h0030 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0
            || obs_vec !== exp_vec) begin
            fails++; $display("FAIL cpu_read_issue got %h want %h", obs_vec, exp_vec);
        end
        tick();
        drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0);
        settle();
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h9D || bus.dma_rvalid !== 1'b0
            || obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL cpu_read_return got rvalid=%b rdata=%h dma_rvalid=%b want 1 9d 0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid);
        end
        tick();
    endtask

    task automatic test_starvation();
        bit want_dma;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 16'($urandom), 8'h0, 1, 0, 16'($urandom), 8'h0, 0, 0);
            settle();
            want_dma = (i == 4) || (i == 9);
            checks++;
            if (bus.dma_gnt !== want_dma || bus.owner !== want_dma || bus.cpu_rdy !== !want_dma
                || obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL starvation cyc %0d got gnt=%b owner=%b rdy=%b want gnt=%b (vec %h want %h)",
                         i, bus.dma_gnt, bus.owner, bus.cpu_rdy, want_dma, obs_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_lock_burst();
        drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0);
        settle(); tick();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       drive(0, 0, 16'h0100, 8'h00, 1, 1, 16'h0200, 8'hA0, 1, 0);
                1, 2:    drive(1, 0, 16'h0100, 8'h00, 1, 1, 16'(16'h0200 + i), 8'(8'hA0 + i), 1, 0);
                3:       drive(1, 0, 16'h0100, 8'h00, 0, 0, 16'h0, 8'h0, 1, 0);
                4:       drive(1, 0, 16'h0100, 8'h00, 0, 0, 16'h0, 8'h0, 0, 0);
                default: drive(1, 0, 16'h0100, 8'h00, 0, 0, 16'h0, 8'h0, 0, 0);
            endcase
            settle();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL lock_vec step %0d got %h want %h", i, obs_vec, exp_vec);
            end
            checks++;
            if ((i < 5 && bus.cpu_rdy !== 1'b0) || (i >= 3 && i < 5 && bus.mem_en !== 1'b0)
                || (i < 3 && (bus.dma_gnt !== 1'b1 || bus.mem_addr !== 16'(16'h0200 + i)))
                || (i == 5 && (bus.cpu_rdy !== 1'b1 || bus.mem_en !== 1'b1 || bus.owner !== 1'b0))) begin
                fails++;
                $display("FAIL lock_burst step %0d got rdy=%b en=%b gnt=%b addr=%h owner=%b",
                         i, bus.cpu_rdy, bus.mem_en, bus.dma_gnt, bus.mem_addr, bus.owner);
            end
            tick();
        end
        checks++;
        if (ram[16'h0201] !== 8'hA1) begin
            fails++; $display("FAIL lock_write got %h want a1", ram[16'h0201]);
        end
    endtask

    task automatic test_dma_alone();
        ram[16'hFFFC] = 8'h00;
        drive(0, 0, 16'h0, 8'h0, 1, 0, 16'hFFFC, 8'h0, 0, 0);
        settle();
        checks++;
        if (bus.dma_gnt !== 1'b1 || bus.mem_addr !== 16'hFFFC || obs_vec !== exp_vec) begin
            fails++; $display("FAIL dma_alone_issue got %h want %h", obs_vec, exp_vec);
        end
        tick();
        // Both request next: counter restarted, so the CPU must win.
        drive(1, 0, 16'h0040, 8'h0, 1, 0, 16'h0041, 8'h0, 0, 0);
        settle();
        checks++;
        if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 8'h00 || bus.cpu_rvalid !== 1'b0
            || bus.owner !== 1'b0 || obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL dma_alone_return got rvalid=%b rdata=%h owner=%b want 1 00 0",
                     bus.dma_rvalid, bus.dma_rdata, bus.owner);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0);
        settle(); tick();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0300, 8'h0, 1, 0);
                1:       drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0301, 8'h0, 1, 1);
                2:       drive(0, 0, 16'h0, 8'h0, 1, 0, 16'h0302, 8'h0, 1, 0);
                default: drive(1, 0, 16'h0055, 8'h0, 0, 0, 16'h0, 8'h0, 1, 0);
            endcase
            settle();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL rst_mid_vec step %0d got %h want %h", i, obs_vec, exp_vec);
            end
            checks++;
            if ((i == 0 && bus.dma_gnt !== 1'b1)
                || (i > 0 && (bus.dma_rvalid !== 1'b0 || bus.cpu_rdy !== 1'b1))
                || (i == 3 && (bus.mem_en !== 1'b1 || bus.owner !== 1'b0))) begin
                fails++;
                $display("FAIL rst_mid step %0d got gnt=%b rvalid=%b rdy=%b en=%b owner=%b",
                         i, bus.dma_gnt, bus.dma_rvalid, bus.cpu_rdy, bus.mem_en, bus.owner);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom), 16'($urandom_range(0, 31)),
                  8'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom),
                  16'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                  $urandom_range(0, 59) == 0);
            settle();
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL random cyc %0d got %h want %h", cyc, obs_vec, exp_vec);
            end
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
        bus.mem_rdata = 8'h00;
        drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 1);
        m_locked = 0; m_waited = 0; m_rd_pend = 0; m_rd_owner = 0; m_rd_data = 0; m_post = 1;
        @(posedge ph1);
        #1;
        test_reset();
        test_idle();
        test_cpu_read();
        test_starvation();
        test_lock_burst();
        test_dma_alone();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
